// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions: the PC-1 and PC-2 permutation tables,
// the per-round left (encrypt) and right (decrypt) rotation amounts, and the
// helper functions built on them. Used by the iterative key schedule and by
// the datapath round stage.
//
// Bit numbering follows DES: index 0 of every [0:N-1] vector is DES bit 1.
// Table entries are the 1-based DES bit numbers exactly as published, so the
// tables can be compared against the standard by eye.
// -----------------------------------------------------------------------------
package des_pkg;

  // Key-schedule control states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

  // PC-1: 64-bit key -> 56-bit C||D (parity bits 8,16,..,64 never selected)
  localparam logic [6:0] PC1_TAB [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // PC-2: 56-bit C||D -> 48-bit round subkey
  localparam logic [5:0] PC2_TAB [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Left rotation applied before subkey j (index j-1), encrypt order
  localparam logic [1:0] LS_TAB [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Right rotation applied before subkey j (index j-1), decrypt order.
  // The first entry is 0 because PC-1 output already equals C16/D16
  // (the left shifts sum to a full 28-bit turn).
  localparam logic [1:0] RS_TAB [0:15] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Permuted choice 1
  function automatic logic [0:55] pc1(input logic [0:63] key);
    logic [0:55] r;
    for (int i = 0; i < 56; i++) begin
      r[i] = key[6'(PC1_TAB[i] - 7'd1)];
    end
    return r;
  endfunction

  // Permuted choice 2
  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    for (int i = 0; i < 48; i++) begin
      r[i] = cd[6'(PC2_TAB[i] - 6'd1)];
    end
    return r;
  endfunction

  // Circular left rotation of a 28-bit half (towards index 0 / DES bit 1)
  function automatic logic [0:27] rotl28(input logic [0:27] x, input logic [1:0] n);
    return (x << n) | (x >> (5'd28 - {3'b000, n}));
  endfunction

  // Circular right rotation of a 28-bit half (towards index 27 / DES bit 28)
  function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] n);
    return (x >> n) | (x << (5'd28 - {3'b000, n}));
  endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Combinational PC-2 compression of the 56-bit C||D register pair into a
// 48-bit round subkey. Shared between the iterative and pipelined schedules.
//
// Ports:
//   cd  in  56  [0:55] C (bits 0..27) concatenated with D (bits 28..55)
//   k   out 48  [0:47] round subkey
// -----------------------------------------------------------------------------
module des_pc2
  import des_pkg::*;
(
  input  logic [0:55] cd,
  output logic [0:47] k
);

  // Pure bit selection, no logic levels beyond wiring
  always_comb begin
    k = pc2(cd);
  end

endmodule

// File: rtl/des_key_sched.sv
// -----------------------------------------------------------------------------
// des_key_sched
// Iterative DES key schedule. On an accepted start the key is loaded through
// PC-1, the first rotation is applied in the same edge, and the subkeys are
// then presented one per valid/ready handshake. Decrypt order is produced by
// rotating C/D to the right, so no subkey storage is needed.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   key_in    in  64   [0:63] DES key incl. parity bits
//   decrypt   in   1   0: K1..Kn order, 1: K16..K(17-n) order; sampled with start
//   start     in   1   load key when idle, ignored while busy
//   busy      out  1   high from accepted start until final handshake
//   sk_valid  out  1   sk_out/sk_idx valid
//   sk_ready  in   1   consumer accepts the subkey when sk_valid && sk_ready
//   sk_out    out 48   [0:47] current subkey
//   sk_idx    out  4   DES round number of sk_out minus 1
//   done      out  1   one-cycle pulse after the final handshake
//
// Parameter:
//   NUM_ROUNDS  subkeys emitted per key (1..16)
// -----------------------------------------------------------------------------
module des_key_sched
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:63] key_in,
  input  logic        decrypt,
  input  logic        start,
  output logic        busy,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [0:47] sk_out,
  output logic [3:0]  sk_idx,
  output logic        done
);

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  ks_state_e   state_r;
  logic [3:0]  cnt_r;
  logic [0:27] c_r;
  logic [0:27] d_r;
  logic        dec_r;
  logic [0:47] sk_out_r;
  logic [3:0]  sk_idx_r;
  logic        sk_valid_r;
  logic        busy_r;
  logic        done_r;

  logic [0:55] cd_base_s;
  logic [3:0]  sh_idx_s;
  logic        dec_sel_s;
  logic [0:27] c_nxt_s;
  logic [0:27] d_nxt_s;
  logic [0:55] cd_nxt_s;
  logic [0:47] sk_nxt_s;
  logic        adv_s;

  // Rotation source: fresh PC-1 of the key while idle, current C/D while running.
  // While running, the next subkey is j = cnt_r + 2, whose table index is cnt_r + 1.
  // After the final subkey this index may wrap, but the result is never loaded.
  always_comb begin
    cd_base_s = {c_r, d_r};
    sh_idx_s  = cnt_r + 4'd1;
    dec_sel_s = dec_r;
    if (state_r == ST_IDLE) begin
      cd_base_s = pc1(key_in);
      sh_idx_s  = 4'd0;
      dec_sel_s = decrypt;
    end else begin
      cd_base_s = {c_r, d_r};
      sh_idx_s  = cnt_r + 4'd1;
      dec_sel_s = dec_r;
    end
  end

  // Next C/D: each 28-bit half rotates independently, left or right by table amount
  always_comb begin
    c_nxt_s = cd_base_s[0:27];
    d_nxt_s = cd_base_s[28:55];
    if (dec_sel_s) begin
      c_nxt_s = rotr28(cd_base_s[0:27],  RS_TAB[sh_idx_s]);
      d_nxt_s = rotr28(cd_base_s[28:55], RS_TAB[sh_idx_s]);
    end else begin
      c_nxt_s = rotl28(cd_base_s[0:27],  LS_TAB[sh_idx_s]);
      d_nxt_s = rotl28(cd_base_s[28:55], LS_TAB[sh_idx_s]);
    end
  end

  // Concatenate rotated halves for compression
  always_comb begin
    cd_nxt_s = {c_nxt_s, d_nxt_s};
  end

  des_pc2 u_pc2 (
    .cd (cd_nxt_s),
    .k  (sk_nxt_s)
  );

  // Handshake only counts while running
  always_comb begin
    adv_s = (state_r == ST_RUN) && sk_valid_r && sk_ready;
  end

  // Control FSM, round counter and registered datapath/outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      c_r        <= 28'd0;
      d_r        <= 28'd0;
      dec_r      <= 1'b0;
      sk_out_r   <= 48'd0;
      sk_idx_r   <= 4'd0;
      sk_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= ST_RUN;
            busy_r     <= 1'b1;
            sk_valid_r <= 1'b1;
            dec_r      <= decrypt;
            cnt_r      <= 4'd0;
            c_r        <= c_nxt_s;
            d_r        <= d_nxt_s;
            sk_out_r   <= sk_nxt_s;
            sk_idx_r   <= decrypt ? 4'd15 : 4'd0;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_RUN: begin
          done_r <= 1'b0;
          if (adv_s) begin
            if (cnt_r == LAST_CNT) begin
              // Last subkey taken: sk_out/sk_idx keep their final value
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              sk_valid_r <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              cnt_r    <= cnt_r + 4'd1;
              c_r      <= c_nxt_s;
              d_r      <= d_nxt_s;
              sk_out_r <= sk_nxt_s;
              // Decrypt index for subkey j = cnt_r + 2 is 16 - j = 14 - cnt_r
              sk_idx_r <= dec_r ? (4'd14 - cnt_r) : (cnt_r + 4'd1);
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          sk_valid_r <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign sk_valid = sk_valid_r;
  assign sk_out   = sk_out_r;
  assign sk_idx   = sk_idx_r;
  assign done     = done_r;

endmodule

// File: tb/tb_des_key_sched.sv
// -----------------------------------------------------------------------------
// tb_des_key_sched
// Randomized self-checking bench for des_key_sched. Expected subkeys come from
// a direct software key schedule: subkey Kr = PC-2 of C0/D0 rotated left by the
// cumulative shift total, built on ordinary [63:0] integer vectors. Two
// instances: the full 16-round build and a NUM_ROUNDS=4 build.
// -----------------------------------------------------------------------------
module tb_des_key_sched;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR_FLIP = 64'h0101010101010101;

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        decrypt;
  logic        start;
  logic        start4;
  logic        sk_ready;
  logic        busy, busy4;
  logic        sk_valid, sk_valid4;
  logic [47:0] sk_out, sk_out4;
  logic [3:0]  sk_idx, sk_idx4;
  logic        done, done4;

  int tests_run;
  int tests_failed;

  des_key_sched #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .start(start),
    .busy(busy), .sk_valid(sk_valid), .sk_ready(sk_ready), .sk_out(sk_out),
    .sk_idx(sk_idx), .done(done)
  );

  des_key_sched #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .start(start4),
    .busy(busy4), .sk_valid(sk_valid4), .sk_ready(sk_ready), .sk_out(sk_out4),
    .sk_idx(sk_idx4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Subkey K<r> (r = 1..16) of a 64-bit key, DES bit p held in vector bit 64-p
  function automatic logic [47:0] model_key(input logic [63:0] key, input int r);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k;
    int s;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1[i]];
      d[27-i] = key[64-PC1[28+i]];
    end
    s = 0;
    for (int j = 0; j < r; j++) s += SHIFTS[j];
    s = s % 28;
    c = (c << s) | (c >> (28 - s));
    d = (d << s) | (d >> (28 - s));
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
    return k;
  endfunction

  // One full key sequence; begins driving start in the current cycle
  task automatic run_seq(input logic [63:0] key, input logic [63:0] model_k, input logic dec,
                         input bit sel4, input bit stall,
                         output logic [47:0] first_k, output logic [47:0] last_k);
    int nr, acc, cyc;
    logic [47:0] exp_k [16];
    logic [3:0]  exp_i [16];
    nr = sel4 ? 4 : 16;
    for (int j = 1; j <= nr; j++) begin
      if (dec) begin
        exp_k[j-1] = model_key(model_k, 17 - j);
        exp_i[j-1] = 4'(16 - j);
      end else begin
        exp_k[j-1] = model_key(model_k, j);
        exp_i[j-1] = 4'(j - 1);
      end
    end
    key_in  = key;
    decrypt = dec;
    sk_ready = 1'b1;
    if (sel4) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
    check_eq("busy_after_start", 64'(sel4 ? busy4 : busy), 64'd1);
    first_k = sel4 ? sk_out4 : sk_out;
    acc = 0;
    cyc = 0;
    while (acc < nr && cyc < 1000) begin
      check_eq("sk_valid", 64'(sel4 ? sk_valid4 : sk_valid), 64'd1);
      check_eq("sk_out",   64'(sel4 ? sk_out4 : sk_out), 64'(exp_k[acc]));
      check_eq("sk_idx",   64'(sel4 ? sk_idx4 : sk_idx), 64'(exp_i[acc]));
      sk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && !sel4) begin
        // Disturbances while busy that must have no effect
        start   = 1'($urandom_range(0, 1));
        key_in  = {$urandom(), $urandom()};
        decrypt = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (sk_ready) acc++;
      cyc++;
    end
    start    = 1'b0;
    sk_ready = 1'b1;
    check_eq("accept_count", 64'(acc), 64'(nr));
    if (!stall) check_eq("back_to_back_cycles", 64'(cyc), 64'(nr));
    check_eq("done_pulse", 64'(sel4 ? done4 : done), 64'd1);
    check_eq("busy_off",   64'(sel4 ? busy4 : busy), 64'd0);
    check_eq("valid_off",  64'(sel4 ? sk_valid4 : sk_valid), 64'd0);
    check_eq("sk_out_hold", 64'(sel4 ? sk_out4 : sk_out), 64'(exp_k[nr-1]));
    check_eq("sk_idx_hold", 64'(sel4 ? sk_idx4 : sk_idx), 64'(exp_i[nr-1]));
    last_k = sel4 ? sk_out4 : sk_out;
  endtask

  initial begin
    logic [47:0] f, l;
    logic [63:0] rk;
    logic        rd;
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    key_in   = 64'd0;
    decrypt  = 1'b0;
    start    = 1'b0;
    start4   = 1'b0;
    sk_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy",  64'(busy), 64'd0);
    check_eq("rst_valid", 64'(sk_valid), 64'd0);
    check_eq("rst_done",  64'(done), 64'd0);
    check_eq("rst_sk_out", 64'(sk_out), 64'd0);
    check_eq("rst_sk_idx", 64'(sk_idx), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer encrypt, then decrypt
    run_seq(KEY_A, KEY_A, 1'b0, 1'b0, 1'b0, f, l);
    check_eq("kat_enc_first", 64'(f), 64'h1B02EFFC7072);
    check_eq("kat_enc_last",  64'(l), 64'hCB3D8B0E17F5);
    @(negedge clk);
    check_eq("done_one_cycle", 64'(done), 64'd0);
    run_seq(KEY_A, KEY_A, 1'b1, 1'b0, 1'b0, f, l);
    check_eq("kat_dec_first", 64'(f), 64'hCB3D8B0E17F5);
    check_eq("kat_dec_last",  64'(l), 64'h1B02EFFC7072);
    @(negedge clk);

    // Random keys with 50% ready stalls and ignored start pulses
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom(), $urandom()};
      rd = 1'($urandom_range(0, 1));
      run_seq(rk, rk, rd, 1'b0, 1'b1, f, l);
      @(negedge clk);
    end

    // Reset while handshake 7 is pending
    key_in   = KEY_A;
    decrypt  = 1'b0;
    sk_ready = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_idx", 64'(sk_idx), 64'd6);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(sk_valid), 64'd0);
    check_eq("mid_rst_busy",  64'(busy), 64'd0);
    check_eq("mid_rst_done",  64'(done), 64'd0);
    check_eq("mid_rst_sk_out", 64'(sk_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seq(KEY_A, KEY_A, 1'b0, 1'b0, 1'b0, f, l);
    check_eq("after_rst_k1", 64'(f), 64'h1B02EFFC7072);

    // Parity-only key differences, then a start on the done cycle
    @(negedge clk);
    run_seq(KEY_A ^ PAR_FLIP, KEY_A, 1'b0, 1'b0, 1'b1, f, l);
    rk = {$urandom(), $urandom()};
    run_seq(rk, rk, 1'b1, 1'b0, 1'b0, f, l);
    @(negedge clk);

    // Reduced-round build
    run_seq(KEY_A, KEY_A, 1'b0, 1'b1, 1'b0, f, l);
    @(negedge clk);
    run_seq(KEY_A, KEY_A, 1'b1, 1'b1, 1'b1, f, l);
    @(negedge clk);
    check_eq("nr4_done_low", 64'(done4), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
